kbd_mouse_feeder: RTL and testbench
===================================

// Module: kbd_mouse_feeder
// PURPOSE
//  Upstream input stage for the minimig core. Queues Amiga raw keycodes and
//  accumulates relative mouse motion from the host/USB side, then serialises
//  them onto the toggle-level kbd_mouse_{level,type,data} bus that minimig
//  consumes. Also registers the mouse buttons. Consumer samples on clk7_en.
// PARAMETERS
//  KBD_DEPTH   8    keycode FIFO entries (power of two, >=2)
//  GAP_CYCLES  64   min clk_sys cycles between level toggles (>=8)
// PORTS
//  clk_sys         in   1   system clock (28.6875 MHz)
//  reset_n         in   1   asynchronous reset, active low
//  key_strobe      in   1   1-cycle pulse: key_code valid
//  key_code        in   8   Amiga raw keycode, bit7 = key-up
//  mouse_strobe    in   1   1-cycle pulse: mouse_dx/dy valid
//  mouse_dx        in   8   signed X delta
//  mouse_dy        in   8   signed Y delta
//  mouse_btn_in    in   3   mouse buttons, active high
//  kbd_mouse_level out  1   toggles once per new word
//  kbd_mouse_type  out  2   0=mouse X, 1=mouse Y, 2=keyboard (3 never driven)
//  kbd_mouse_data  out  8   payload for kbd_mouse_type
//  mouse_buttons   out  3   mouse_btn_in registered once
//  kbd_overflow    out  1   sticky: keycode dropped because FIFO was full
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, FIFO empty, accumulators
//   0, FSM=IDLE, gap counter 0. Reset mid-word discards all pending data.
//  Key FIFO: push on key_strobe when not full; when full, drop the code and set
//   kbd_overflow (cleared only by reset). Pop and push in the same cycle
//   while full: the pop happens first, so the push is accepted.
//  Mouse accumulators accX/accY: 10-bit signed. On mouse_strobe, add the
//   sign-extended delta and saturate to [-512,+511]. When a word is emitted in
//   the same cycle, acc_next = sat(acc - emitted + delta).
//  Emitted mouse value = clamp(acc, -128, +127); the residue stays in acc.
//  FSM:
//   IDLE: if FIFO non-empty -> SEND_KEY; else if accX!=0 or accY!=0 ->
//    SEND_X; else stay. Keyboard has strict priority over mouse.
//   SEND_KEY: type=2, data=FIFO head, pop, toggle level -> GAP(next=IDLE).
//   SEND_X: type=0, data=clamp(accX), subtract, toggle -> GAP(next=SEND_Y).
//   SEND_Y: type=1, data=clamp(accY) (may be 0), subtract, toggle -> GAP(next=IDLE).
//    X and Y always go out as a pair. A key arriving between them waits until Y is sent.
//   GAP: count GAP_CYCLES-1 cycles, then go to next. Successive level toggles
//    are therefore exactly GAP_CYCLES apart when work is back-to-back.
//  type/data change only in the cycle level toggles and hold until the next toggle.
//  Latency: key_strobe at cycle t with FIFO empty and FSM in IDLE -> level
//   toggles at t+2 (one cycle FIFO write, one cycle SEND).
//  mouse_buttons = mouse_btn_in delayed 1 cycle, independent of the FSM.
// TESTING
//  1 Reset, key_strobe code 0x45 -> level 0->1 at t+2, type=2, data=0x45; no
//    further toggle.
//  2 Push 12 keys in 12 consecutive cycles, DEPTH=8 -> the first 9 keys are
//    emitted (one already popped), 3 dropped, kbd_overflow=1, toggles spaced 64.
//  3 Three mouse_strobes dx=+100, dy=0 -> words X127,Y0,X127,Y0,X46,Y0, then idle.
//  4 mouse dx=-128, dy=+5 plus key 0x20 in the same cycle -> key first, then
//    X0x80, Y0x05.
//  5 key strobe during GAP between X and Y -> order X,Y,key; accumulator
//    saturation: 6x dx=+127 -> acc caps at 511.
//  6 Assert reset_n low mid-GAP with 3 keys queued -> outputs 0 immediately;
//    after release, no toggles; mouse_btn_in=3'b101 -> mouse_buttons=101 next cycle.

Source files
------------

// File: rtl/kbd_mouse_feeder.sv
// Keyboard/mouse front end for minimig: queues raw keycodes, accumulates mouse
// motion and serialises both onto the toggle-level kbd_mouse bus.
module kbd_mouse_feeder #(
  parameter int KBD_DEPTH  = 8,
  parameter int GAP_CYCLES = 64
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              key_strobe,
  input  logic [7:0]        key_code,
  input  logic              mouse_strobe,
  input  logic signed [7:0] mouse_dx,
  input  logic signed [7:0] mouse_dy,
  input  logic [2:0]        mouse_btn_in,
  output logic              kbd_mouse_level,
  output logic [1:0]        kbd_mouse_type,
  output logic [7:0]        kbd_mouse_data,
  output logic [2:0]        mouse_buttons,
  output logic              kbd_overflow
);

  localparam int AW = $clog2(KBD_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, SEND_KEY, SEND_X, SEND_Y, GAP} state_t;

  function automatic logic signed [9:0] sat10(input logic signed [11:0] v);
    if (v > 12'sd511)       return 10'sd511;
    else if (v < -12'sd512) return -10'sd512;
    else                    return $signed(v[9:0]);
  endfunction

  function automatic logic signed [7:0] clamp8(input logic signed [9:0] v);
    if (v > 10'sd127)       return 8'sd127;
    else if (v < -10'sd128) return -8'sd128;
    else                    return $signed(v[7:0]);
  endfunction

  state_t             state_q;
  state_t             after_q;
  logic [GW-1:0]      gap_q;

  logic [7:0]         fifo_q [KBD_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic               full, fifo_ne, push, pop;

  logic signed [9:0]  accx_q, accy_q, accx_d, accy_d;
  logic signed [7:0]  emit_x, emit_y;
  logic signed [11:0] dx_ext, dy_ext;
  logic               mouse_ne;

  assign full     = (cnt_q == (AW+1)'(KBD_DEPTH));
  assign fifo_ne  = (cnt_q != '0);
  assign pop      = (state_q == SEND_KEY);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push     = key_strobe && (!full || pop);
  assign cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign mouse_ne = (accx_q != '0) || (accy_q != '0);

  assign emit_x = (state_q == SEND_X) ? clamp8(accx_q) : '0;
  assign emit_y = (state_q == SEND_Y) ? clamp8(accy_q) : '0;
  assign dx_ext = mouse_strobe ? 12'(mouse_dx) : '0;
  assign dy_ext = mouse_strobe ? 12'(mouse_dy) : '0;
  assign accx_d = sat10(12'(accx_q) - 12'(emit_x) + dx_ext);
  assign accy_d = sat10(12'(accy_q) - 12'(emit_y) + dy_ext);

  always_ff @(posedge clk_sys) begin
    if (push) fifo_q[wr_ptr_q] <= key_code;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      kbd_overflow  <= 1'b0;
      accx_q        <= '0;
      accy_q        <= '0;
      mouse_buttons <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q         <= cnt_d;
      if (key_strobe && !push) kbd_overflow <= 1'b1;
      accx_q        <= accx_d;
      accy_q        <= accy_d;
      mouse_buttons <= mouse_btn_in;
    end
  end

  // GAP returning to IDLE makes the IDLE decision itself, so back-to-back
  // words toggle the level exactly GAP_CYCLES apart.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      after_q         <= IDLE;
      gap_q           <= '0;
      kbd_mouse_level <= 1'b0;
      kbd_mouse_type  <= 2'd0;
      kbd_mouse_data  <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_ne)       state_q <= SEND_KEY;
          else if (mouse_ne) state_q <= SEND_X;
        end
        SEND_KEY: begin
          kbd_mouse_type  <= 2'd2;
          kbd_mouse_data  <= fifo_q[rd_ptr_q];
          kbd_mouse_level <= ~kbd_mouse_level;
          after_q         <= IDLE;
          gap_q           <= '0;
          state_q         <= GAP;
        end
        SEND_X: begin
          kbd_mouse_type  <= 2'd0;
          kbd_mouse_data  <= emit_x;
          kbd_mouse_level <= ~kbd_mouse_level;
          after_q         <= SEND_Y;
          gap_q           <= '0;
          state_q         <= GAP;
        end
        SEND_Y: begin
          kbd_mouse_type  <= 2'd1;
          kbd_mouse_data  <= emit_y;
          kbd_mouse_level <= ~kbd_mouse_level;
          after_q         <= IDLE;
          gap_q           <= '0;
          state_q         <= GAP;
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 2)) begin
            if (after_q == SEND_Y) state_q <= SEND_Y;
            else if (fifo_ne)      state_q <= SEND_KEY;
            else if (mouse_ne)     state_q <= SEND_X;
            else                   state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_mouse_feeder.sv
// Directed bench for kbd_mouse_feeder: logs every level toggle and compares
// the word stream, spacing and side outputs against hand-computed values.
module tb_kbd_mouse_feeder;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              key_strobe = 1'b0;
  logic [7:0]        key_code = '0;
  logic              mouse_strobe = 1'b0;
  logic signed [7:0] mouse_dx = '0;
  logic signed [7:0] mouse_dy = '0;
  logic [2:0]        mouse_btn_in = '0;
  logic              kbd_mouse_level;
  logic [1:0]        kbd_mouse_type;
  logic [7:0]        kbd_mouse_data;
  logic [2:0]        mouse_buttons;
  logic              kbd_overflow;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic lvl_prev = 1'b0;
  int q_typ[$];
  int q_dat[$];
  int q_cyc[$];

  kbd_mouse_feeder #(.KBD_DEPTH(8), .GAP_CYCLES(64)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .key_strobe(key_strobe), .key_code(key_code),
    .mouse_strobe(mouse_strobe), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .mouse_btn_in(mouse_btn_in),
    .kbd_mouse_level(kbd_mouse_level), .kbd_mouse_type(kbd_mouse_type),
    .kbd_mouse_data(kbd_mouse_data), .mouse_buttons(mouse_buttons),
    .kbd_overflow(kbd_overflow)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      lvl_prev = 1'b0;
    end else if (kbd_mouse_level !== lvl_prev) begin
      lvl_prev = kbd_mouse_level;
      q_typ.push_back(int'(kbd_mouse_type));
      q_dat.push_back(int'(kbd_mouse_data));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_words(input string tag, input int et[$], input int ed[$]);
    chk($sformatf("%s.count", tag), q_typ.size(), et.size());
    for (int i = 0; i < et.size() && i < q_typ.size(); i++) begin
      chk($sformatf("%s[%0d].type", tag, i), q_typ[i], et[i]);
      chk($sformatf("%s[%0d].data", tag, i), q_dat[i], ed[i]);
      if (i > 0) chk($sformatf("%s[%0d].gap", tag, i), q_cyc[i] - q_cyc[i-1], 64);
    end
  endtask

  task automatic clear_log();
    q_typ.delete();
    q_dat.delete();
    q_cyc.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_key(input logic [7:0] code);
    key_strobe = 1'b1;
    key_code   = code;
    @(negedge clk_sys);
    key_strobe = 1'b0;
  endtask

  task automatic send_mouse(input logic [7:0] dx, input logic [7:0] dy);
    mouse_strobe = 1'b1;
    mouse_dx     = dx;
    mouse_dy     = dy;
    @(negedge clk_sys);
    mouse_strobe = 1'b0;
    mouse_dx     = '0;
    mouse_dy     = '0;
  endtask

  initial begin
    int t0;
    int et[$];
    int ed[$];

    // 1: reset values, single key latency
    wait_cyc(3);
    chk("rst.level", kbd_mouse_level, 0);
    chk("rst.type", kbd_mouse_type, 0);
    chk("rst.data", kbd_mouse_data, 0);
    chk("rst.buttons", mouse_buttons, 0);
    chk("rst.overflow", kbd_overflow, 0);
    reset_n = 1'b1;
    wait_cyc(2);
    t0 = cyc + 1;
    send_key(8'h45);
    wait_cyc(200);
    et = '{2}; ed = '{8'h45};
    chk_words("t1", et, ed);
    if (q_cyc.size() > 0) chk("t1.latency", q_cyc[0] - t0, 2);
    chk("t1.level", kbd_mouse_level, 1);
    chk("t1.no_ovf", kbd_overflow, 0);

    // 2: 12 keys back to back into an 8-deep FIFO
    clear_log();
    for (int i = 0; i < 12; i++) begin
      key_strobe = 1'b1;
      key_code   = 8'h10 + 8'(i);
      @(negedge clk_sys);
    end
    key_strobe = 1'b0;
    wait_cyc(700);
    et = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    ed = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    chk_words("t2", et, ed);
    chk("t2.overflow", kbd_overflow, 1);

    // 3: three +100 X deltas drain as 127,127,46 with Y words in between
    clear_log();
    for (int i = 0; i < 3; i++) send_mouse(8'd100, 8'd0);
    wait_cyc(500);
    et = '{0, 1, 0, 1, 0, 1};
    ed = '{127, 0, 127, 0, 46, 0};
    chk_words("t3", et, ed);

    // 4: key beats mouse arriving in the same cycle
    clear_log();
    key_strobe = 1'b1;
    key_code   = 8'h20;
    send_mouse(8'h80, 8'h05);
    key_strobe = 1'b0;
    wait_cyc(300);
    et = '{2, 0, 1};
    ed = '{8'h20, 8'h80, 8'h05};
    chk_words("t4", et, ed);

    // 5a: key arriving between X and Y waits for Y
    clear_log();
    send_mouse(8'd10, 8'hFD);
    wait_cyc(20);
    send_key(8'h33);
    wait_cyc(300);
    et = '{0, 1, 2};
    ed = '{8'h0A, 8'hFD, 8'h33};
    chk_words("t5a", et, ed);

    // 5b: 6 x +127 while busy saturates at 511 -> 127 x4 then 3
    clear_log();
    send_key(8'h01);
    wait_cyc(3);
    for (int i = 0; i < 6; i++) send_mouse(8'd127, 8'd0);
    wait_cyc(850);
    et = '{2, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    ed = '{8'h01, 127, 0, 127, 0, 127, 0, 127, 0, 3, 0};
    chk_words("t5b", et, ed);

    // 6: asynchronous reset mid-GAP with keys still queued
    clear_log();
    for (int i = 0; i < 4; i++) begin
      key_strobe = 1'b1;
      key_code   = 8'h41 + 8'(i);
      @(negedge clk_sys);
    end
    key_strobe = 1'b0;
    wait_cyc(20);
    chk("t6.pre.data", kbd_mouse_data, 8'h41);
    #3 reset_n = 1'b0;
    #1;
    chk("t6.rst.level", kbd_mouse_level, 0);
    chk("t6.rst.type", kbd_mouse_type, 0);
    chk("t6.rst.data", kbd_mouse_data, 0);
    chk("t6.rst.overflow", kbd_overflow, 0);
    wait_cyc(3);
    reset_n = 1'b1;
    clear_log();
    wait_cyc(300);
    chk("t6.no_toggle", q_typ.size(), 0);
    chk("t6.level", kbd_mouse_level, 0);
    mouse_btn_in = 3'b101;
    #1;
    chk("t6.btn.before", mouse_buttons, 3'b000);
    @(negedge clk_sys);
    chk("t6.btn.after", mouse_buttons, 3'b101);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
